// File: rtl/hazard_unit.sv
// Tracks E/M/W writer records and derives the D-stage stall plus D/E/M forwarding selects.
// Latency: outputs are combinational from current D inputs and records; no backpressure beyond stall itself.
module hazard_unit #(
  parameter int REG_W  = 5,
  parameter int TNEW_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_W-1:0]  D_rs,
  input  logic [REG_W-1:0]  D_rt,
  input  logic [TNEW_W-1:0] D_tuse_rs,
  input  logic [TNEW_W-1:0] D_tuse_rt,
  input  logic [REG_W-1:0]  D_dst,
  input  logic [1:0]        D_wsrc,
  output logic              stall,
  output logic [2:0]        DrsSel,
  output logic [2:0]        DrtSel,
  output logic [2:0]        ErsSel,
  output logic [2:0]        ErtSel,
  output logic [2:0]        MrtSel
);

  typedef struct packed {
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  dst;
    logic [1:0]        wsrc;
    logic [TNEW_W-1:0] tnew;
  } rec_t;

  localparam logic [1:0]        WSRC_MEM  = 2'd1;
  localparam logic [1:0]        WSRC_PC8  = 2'd2;
  localparam logic [TNEW_W-1:0] TUSE_NONE = '1;

  rec_t e_rec, m_rec, w_rec;
  logic [TNEW_W-1:0] tnew0;

  // A record with dst=0 (bubble or $0 writer) can never match a nonzero source.
  function automatic logic hit(input logic [REG_W-1:0] r, input rec_t rec);
    return (r != '0) && (r == rec.dst);
  endfunction

  function automatic logic src_stall(input logic [REG_W-1:0] r, input logic [TNEW_W-1:0] tuse,
                                     input rec_t e, input rec_t m);
    if (tuse == TUSE_NONE) return 1'b0;
    if (hit(r, e)) return e.tnew > tuse;
    if (hit(r, m)) return m.tnew > tuse;
    return 1'b0;
  endfunction

  function automatic logic [2:0] d_sel(input logic [REG_W-1:0] r, input rec_t e, input rec_t m,
                                       input rec_t w);
    if (hit(r, e)) return (e.wsrc == WSRC_PC8) ? 3'd1 : 3'd0;
    if (hit(r, m)) begin
      if (m.wsrc == WSRC_PC8) return 3'd3;
      if (m.wsrc == WSRC_MEM) return 3'd0;
      return 3'd2;
    end
    if (hit(r, w)) return (w.wsrc == WSRC_PC8) ? 3'd5 : 3'd4;
    return 3'd0;
  endfunction

  function automatic logic [2:0] e_sel(input logic [REG_W-1:0] r, input rec_t m, input rec_t w);
    if (hit(r, m)) begin
      if (m.wsrc == WSRC_PC8) return 3'd2;
      if (m.wsrc == WSRC_MEM) return 3'd0;
      return 3'd1;
    end
    if (hit(r, w)) return (w.wsrc == WSRC_PC8) ? 3'd4 : 3'd3;
    return 3'd0;
  endfunction

  function automatic logic [2:0] m_sel(input logic [REG_W-1:0] r, input rec_t w);
    if (hit(r, w)) return (w.wsrc == WSRC_PC8) ? 3'd2 : 3'd1;
    return 3'd0;
  endfunction

  always_comb begin
    tnew0 = TNEW_W'(1);
    if (D_wsrc == WSRC_PC8)      tnew0 = '0;
    else if (D_wsrc == WSRC_MEM) tnew0 = TNEW_W'(2);
  end

  always_comb begin
    stall  = src_stall(D_rs, D_tuse_rs, e_rec, m_rec) | src_stall(D_rt, D_tuse_rt, e_rec, m_rec);
    DrsSel = d_sel(D_rs, e_rec, m_rec, w_rec);
    DrtSel = d_sel(D_rt, e_rec, m_rec, w_rec);
    ErsSel = e_sel(e_rec.rs, m_rec, w_rec);
    ErtSel = e_sel(e_rec.rt, m_rec, w_rec);
    MrtSel = m_sel(m_rec.rt, w_rec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_rec <= '0;
      m_rec <= '0;
      w_rec <= '0;
    end else begin
      if (stall) begin
        e_rec <= '0;
      end else begin
        e_rec.rs   <= D_rs;
        e_rec.rt   <= D_rt;
        e_rec.dst  <= D_dst;
        e_rec.wsrc <= D_wsrc;
        e_rec.tnew <= tnew0;
      end
      m_rec      <= e_rec;
      m_rec.tnew <= (e_rec.tnew == '0) ? '0 : e_rec.tnew - TNEW_W'(1);
      w_rec      <= m_rec;
      w_rec.tnew <= '0;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboarded bench for hazard_unit: directed hazard scenarios followed by random traffic.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_rs, D_rt, D_dst;
  logic [1:0] D_tuse_rs, D_tuse_rt, D_wsrc;
  logic       stall;
  logic [2:0] DrsSel, DrtSel, ErsSel, ErtSel, MrtSel;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
    .D_dst(D_dst), .D_wsrc(D_wsrc),
    .stall(stall), .DrsSel(DrsSel), .DrtSel(DrtSel),
    .ErsSel(ErsSel), .ErtSel(ErtSel), .MrtSel(MrtSel)
  );

  typedef struct {
    int rs;
    int rt;
    int dst;
    int wsrc;
  } instr_t;

  typedef struct packed {
    logic       stall;
    logic [2:0] drs;
    logic [2:0] drt;
    logic [2:0] ers;
    logic [2:0] ert;
    logic [2:0] mrt;
  } exp_t;

  // hist[0] is the instruction now in E, hist[1] in M, hist[2] in W.
  instr_t hist[3];
  instr_t bub;
  exp_t   expq[$];
  bit     mvalid = 0;
  bit     last_stall = 0;
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;

  // Cycles a writer of this kind needs after entering E before its value exists.
  function automatic int lat(int ws);
    if (ws == 2) return 0;
    if (ws == 1) return 2;
    return 1;
  endfunction

  function automatic int remaining(instr_t p, int age);
    int r;
    r = lat(p.wsrc) - age;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic int youngest(int r, int from);
    if (r == 0) return -1;
    for (int a = from; a < 3; a++)
      if (hist[a].dst == r) return a;
    return -1;
  endfunction

  function automatic bit pred_stall(int r, int tuse);
    int a;
    if (tuse == 3) return 0;
    a = youngest(r, 0);
    if (a < 0) return 0;
    return remaining(hist[a], a) > tuse;
  endfunction

  // Consumer sits just before stage 'from'; each later stage offers a result port and a pc8 port,
  // except that only pc8 can come out of E.
  function automatic logic [2:0] pick(int r, int from);
    int a;
    int pc8;
    a = youngest(r, from);
    if (a < 0) return 3'd0;
    if (remaining(hist[a], a) > 0) return 3'd0;
    pc8 = (hist[a].wsrc == 2) ? 1 : 0;
    if (from == 0) return 3'(2 * a + pc8);
    return 3'(2 * (a - from) + 1 + pc8);
  endfunction

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, want);
    end
  endtask

  task automatic step(input bit rst, input int rs, input int rt, input int trs, input int trt,
                      input int dst, input int ws);
    exp_t x;
    instr_t n;
    reset = rst;
    D_rs = 5'(rs); D_rt = 5'(rt); D_tuse_rs = 2'(trs); D_tuse_rt = 2'(trt);
    D_dst = 5'(dst); D_wsrc = 2'(ws);
    last_stall = 0;
    if (mvalid) begin
      x.stall = pred_stall(rs, trs) | pred_stall(rt, trt);
      x.drs = pick(rs, 0);
      x.drt = pick(rt, 0);
      x.ers = pick(hist[0].rs, 1);
      x.ert = pick(hist[0].rt, 1);
      x.mrt = pick(hist[1].rt, 2);
      expq.push_back(x);
      last_stall = x.stall;
    end
    @(posedge clk);
    if (rst) begin
      hist[0] = bub; hist[1] = bub; hist[2] = bub;
      mvalid = 1;
    end else if (mvalid) begin
      n.rs = rs; n.rt = rt; n.dst = dst; n.wsrc = ws;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = last_stall ? bub : n;
    end
    #1;
  endtask

  task automatic nop();
    step(0, 0, 0, 3, 3, 0, 0);
  endtask

  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      cyc++;
      if (expq.size() > 0) begin
        x = expq.pop_front();
        chk("stall", {2'b0, stall}, {2'b0, x.stall});
        chk("DrsSel", DrsSel, x.drs);
        chk("DrtSel", DrtSel, x.drt);
        chk("ErsSel", ErsSel, x.ers);
        chk("ErtSel", ErtSel, x.ert);
        chk("MrtSel", MrtSel, x.mrt);
      end
    end
  end

  initial begin
    int rs, rt, trs, trt, dst, ws;
    int regs[4];
    regs[0] = 0; regs[1] = 8; regs[2] = 9; regs[3] = 31;
    bub.rs = 0; bub.rt = 0; bub.dst = 0; bub.wsrc = 0;
    hist[0] = bub; hist[1] = bub; hist[2] = bub;

    step(1, 0, 0, 3, 3, 0, 0);
    step(1, 0, 0, 3, 3, 0, 0);
    nop(); nop();
    // ALU producer then Tuse-1 reader
    step(0, 0, 0, 3, 3, 8, 0); step(0, 8, 0, 1, 3, 0, 0); nop();
    // load-use with Tuse 0: two stall cycles with inputs held
    step(0, 0, 0, 3, 3, 9, 1);
    step(0, 9, 0, 0, 3, 0, 0); step(0, 9, 0, 0, 3, 0, 0); step(0, 9, 0, 0, 3, 0, 0); nop();
    // jal then immediate reader
    step(0, 0, 0, 3, 3, 31, 2); step(0, 31, 0, 0, 3, 0, 0); nop(); nop();
    // back-to-back writers of the same register
    step(0, 0, 0, 3, 3, 10, 0); step(0, 0, 0, 3, 3, 10, 0); step(0, 10, 10, 1, 1, 0, 0); nop();
    // $0 writer and reader
    step(0, 0, 0, 3, 3, 0, 1); step(0, 0, 0, 0, 0, 0, 0); nop();
    // reset in the middle of a load-use stall
    step(0, 0, 0, 3, 3, 9, 1); step(0, 9, 0, 0, 3, 0, 0);
    step(1, 9, 0, 0, 3, 0, 0); step(0, 9, 0, 0, 3, 0, 0); nop(); nop();

    rs = 0; rt = 0; trs = 3; trt = 3; dst = 0; ws = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!last_stall) begin
        rs  = regs[$urandom_range(0, 3)];
        rt  = regs[$urandom_range(0, 3)];
        trs = $urandom_range(0, 3);
        trt = $urandom_range(0, 3);
        dst = regs[$urandom_range(0, 3)];
        ws  = $urandom_range(0, 3);
      end
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, rs, rt, trs, trt, dst, ws);
    end
    nop();
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d expected=0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
